// File: rtl/timer_setup.sv
// Countdown-timer preset entry: synchronised plus/minus buttons step a two-digit BCD value with press-and-hold auto-repeat.
// Optional feature macro TIMER_SETUP_WRAP_EN: 99 min <-> 00 s wrap instead of saturating at both ends.
module timer_setup #(
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       plus,
    input  logic       minus,
    output logic [3:0] hi,
    output logic [3:0] lo,
    output logic       seconds
);

    localparam int CW = $clog2(REPEAT_DELAY + 1);
    localparam logic [CW-1:0] DELAY_C  = CW'(REPEAT_DELAY);
    // Reloading here makes the counter hit DELAY_C again exactly REPEAT_RATE cycles later.
    localparam logic [CW-1:0] RELOAD_C = CW'(REPEAT_DELAY - REPEAT_RATE + 1);

    typedef struct packed {
        logic [3:0] hi;
        logic [3:0] lo;
        logic       sec;
    } preset_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLUS,
        S_MINUS,
        S_BLOCKED
    } state_t;

    logic          plus_meta_q, plus_sync_q, plus_prev_q;
    logic          minus_meta_q, minus_sync_q, minus_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    state_t        state_q, state_d;
    preset_t       preset_q, preset_d;
    logic          do_up, do_dn;

    function automatic preset_t bcd_inc(preset_t p);
        preset_t r = p;
        if (p.lo == 4'd9) begin
            r.lo = 4'd0;
            r.hi = p.hi + 4'd1;
        end else begin
            r.lo = p.lo + 4'd1;
        end
        return r;
    endfunction

    function automatic preset_t bcd_dec(preset_t p);
        preset_t r = p;
        if (p.lo == 4'd0) begin
            r.lo = 4'd9;
            r.hi = p.hi - 4'd1;
        end else begin
            r.lo = p.lo - 4'd1;
        end
        return r;
    endfunction

    function automatic preset_t step_up(preset_t p);
        preset_t r;
        if (p.sec) begin
            if (p.hi == 4'd5 && p.lo == 4'd9) r = '{hi: 4'd0, lo: 4'd1, sec: 1'b0};
            else                              r = bcd_inc(p);
        end else if (p.hi == 4'd9 && p.lo == 4'd9) begin
`ifdef TIMER_SETUP_WRAP_EN
            r = '{hi: 4'd0, lo: 4'd0, sec: 1'b1};
`else
            r = p;
`endif
        end else begin
            r = bcd_inc(p);
        end
        return r;
    endfunction

    function automatic preset_t step_dn(preset_t p);
        preset_t r;
        if (!p.sec) begin
            if (p.hi == 4'd0 && p.lo == 4'd1) r = '{hi: 4'd5, lo: 4'd9, sec: 1'b1};
            else                              r = bcd_dec(p);
        end else if (p.hi == 4'd0 && p.lo == 4'd0) begin
`ifdef TIMER_SETUP_WRAP_EN
            r = '{hi: 4'd9, lo: 4'd9, sec: 1'b0};
`else
            r = p;
`endif
        end else begin
            r = bcd_dec(p);
        end
        return r;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            plus_meta_q  <= 1'b0;
            plus_sync_q  <= 1'b0;
            plus_prev_q  <= 1'b0;
            minus_meta_q <= 1'b0;
            minus_sync_q <= 1'b0;
            minus_prev_q <= 1'b0;
            cnt_q        <= '0;
            state_q      <= S_IDLE;
            preset_q     <= '{hi: 4'd0, lo: 4'd0, sec: 1'b1};
        end else begin
            plus_meta_q  <= plus;
            plus_sync_q  <= plus_meta_q;
            plus_prev_q  <= plus_sync_q;
            minus_meta_q <= minus;
            minus_sync_q <= minus_meta_q;
            minus_prev_q <= minus_sync_q;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            preset_q     <= preset_d;
        end
    end

    // NOTE: every variable gets a default first so no path through this block infers a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        preset_d = preset_q;
        do_up    = 1'b0;
        do_dn    = 1'b0;

        if (plus_sync_q && minus_sync_q) begin
            state_d = S_BLOCKED;
            cnt_d   = '0;
        end else if (plus_sync_q && !plus_prev_q) begin
            do_up   = 1'b1;
            state_d = S_PLUS;
            cnt_d   = CW'(1);
        end else if (minus_sync_q && !minus_prev_q) begin
            do_dn   = 1'b1;
            state_d = S_MINUS;
            cnt_d   = CW'(1);
        end else begin
            unique case (state_q)
                S_PLUS, S_MINUS: begin
                    if ((state_q == S_PLUS && plus_sync_q) || (state_q == S_MINUS && minus_sync_q)) begin
                        if (cnt_q == DELAY_C) begin
                            do_up = (state_q == S_PLUS);
                            do_dn = (state_q == S_MINUS);
                            cnt_d = RELOAD_C;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
                S_BLOCKED: begin
                    cnt_d = '0;
                    if (!plus_sync_q && !minus_sync_q) state_d = S_IDLE;
                end
                default: cnt_d = '0;
            endcase
        end

        if (do_up)      preset_d = step_up(preset_q);
        else if (do_dn) preset_d = step_dn(preset_q);
    end

    assign hi      = preset_q.hi;
    assign lo      = preset_q.lo;
    assign seconds = preset_q.sec;

endmodule

// File: tb/tb_timer_setup.sv
// Directed self-checking bench for timer_setup: reset, single steps, auto-repeat, boundaries, both-button lockout.
module tb_timer_setup;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       plus = 1'b0;
    logic       minus = 1'b0;
    logic [3:0] hi, lo;
    logic       seconds;
    int         checks = 0;
    int         errors = 0;

    timer_setup dut (
        .clk     (clk),
        .reset   (reset),
        .plus    (plus),
        .minus   (minus),
        .hi      (hi),
        .lo      (lo),
        .seconds (seconds)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        plus  = 1'b0;
        minus = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic hold(input logic p, input logic m, input int n);
        @(negedge clk);
        plus  = p;
        minus = m;
        repeat (n) @(negedge clk);
        plus  = 1'b0;
        minus = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic presses(input logic up, input int n);
        for (int i = 0; i < n; i++) hold(up, !up, 3);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({hi, lo, seconds} !== {4'd0, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got %0d%0d sec=%b, want 00 sec=1", hi, lo, seconds);
        end
    endtask

    task automatic test_minus_saturate();
        hold(1'b0, 1'b1, 2);
        checks++;
`ifdef TIMER_SETUP_WRAP_EN
        if ({hi, lo, seconds} !== {4'd9, 4'd9, 1'b0}) begin
            errors++;
            $display("FAIL minus_at_00: got %0d%0d sec=%b, want 99 sec=0", hi, lo, seconds);
        end
`else
        if ({hi, lo, seconds} !== {4'd0, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL minus_at_00: got %0d%0d sec=%b, want 00 sec=1", hi, lo, seconds);
        end
`endif
    endtask

    task automatic test_plus_single();
        do_reset();
        @(negedge clk);
        plus = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({hi, lo} !== {4'd0, 4'd0}) begin
            errors++;
            $display("FAIL single_latency_early: got %0d%0d after 2 edges, want 00", hi, lo);
        end
        @(negedge clk);
        checks++;
        if ({hi, lo, seconds} !== {4'd0, 4'd1, 1'b1}) begin
            errors++;
            $display("FAIL single_latency_3rd: got %0d%0d sec=%b after 3 edges, want 01 sec=1", hi, lo, seconds);
        end
        repeat (2) @(negedge clk);
        plus = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if ({hi, lo, seconds} !== {4'd0, 4'd1, 1'b1}) begin
            errors++;
            $display("FAIL single_no_repeat: got %0d%0d sec=%b, want 01 sec=1", hi, lo, seconds);
        end
    endtask

    task automatic test_plus_hold();
        do_reset();
        hold(1'b1, 1'b0, 210);
        checks++;
        if ({hi, lo, seconds} !== {4'd2, 4'd4, 1'b1}) begin
            errors++;
            $display("FAIL hold_210: got %0d%0d sec=%b, want 24 sec=1", hi, lo, seconds);
        end
    endtask

    task automatic test_boundaries();
        do_reset();
        presses(1'b1, 59);
        checks++;
        if ({hi, lo, seconds} !== {4'd5, 4'd9, 1'b1}) begin
            errors++;
            $display("FAIL count_to_59: got %0d%0d sec=%b, want 59 sec=1", hi, lo, seconds);
        end
        presses(1'b1, 1);
        checks++;
        if ({hi, lo, seconds} !== {4'd0, 4'd1, 1'b0}) begin
            errors++;
            $display("FAIL plus_at_59s: got %0d%0d sec=%b, want 01 sec=0", hi, lo, seconds);
        end
        presses(1'b0, 1);
        checks++;
        if ({hi, lo, seconds} !== {4'd5, 4'd9, 1'b1}) begin
            errors++;
            $display("FAIL minus_at_01min: got %0d%0d sec=%b, want 59 sec=1", hi, lo, seconds);
        end
        presses(1'b1, 10);
        checks++;
        if ({hi, lo, seconds} !== {4'd1, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL minutes_carry: got %0d%0d sec=%b, want 10 sec=0", hi, lo, seconds);
        end
        presses(1'b0, 1);
        checks++;
        if ({hi, lo, seconds} !== {4'd0, 4'd9, 1'b0}) begin
            errors++;
            $display("FAIL minutes_borrow: got %0d%0d sec=%b, want 09 sec=0", hi, lo, seconds);
        end
        presses(1'b1, 90);
        checks++;
        if ({hi, lo, seconds} !== {4'd9, 4'd9, 1'b0}) begin
            errors++;
            $display("FAIL count_to_99: got %0d%0d sec=%b, want 99 sec=0", hi, lo, seconds);
        end
        presses(1'b1, 1);
        checks++;
`ifdef TIMER_SETUP_WRAP_EN
        if ({hi, lo, seconds} !== {4'd0, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL plus_at_99min: got %0d%0d sec=%b, want 00 sec=1", hi, lo, seconds);
        end
`else
        if ({hi, lo, seconds} !== {4'd9, 4'd9, 1'b0}) begin
            errors++;
            $display("FAIL plus_at_99min: got %0d%0d sec=%b, want 99 sec=0", hi, lo, seconds);
        end
`endif
    endtask

    task automatic test_both_held();
        do_reset();
        presses(1'b1, 10);
        checks++;
        if ({hi, lo, seconds} !== {4'd1, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL seconds_carry: got %0d%0d sec=%b, want 10 sec=1", hi, lo, seconds);
        end
        hold(1'b1, 1'b1, 100);
        checks++;
        if ({hi, lo, seconds} !== {4'd1, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL both_held: got %0d%0d sec=%b, want 10 sec=1", hi, lo, seconds);
        end
        // Release plus first; minus stays high long enough that a repeat would show.
        @(negedge clk);
        plus  = 1'b1;
        minus = 1'b1;
        repeat (20) @(negedge clk);
        plus = 1'b0;
        repeat (60) @(negedge clk);
        minus = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if ({hi, lo, seconds} !== {4'd1, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL release_order: got %0d%0d sec=%b, want 10 sec=1", hi, lo, seconds);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        @(negedge clk);
        plus = 1'b1;
        repeat (50) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({hi, lo, seconds} !== {4'd0, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset_async: got %0d%0d sec=%b, want 00 sec=1", hi, lo, seconds);
        end
        plus = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if ({hi, lo, seconds} !== {4'd0, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset_abort: got %0d%0d sec=%b, want 00 sec=1", hi, lo, seconds);
        end
    endtask

    initial begin
        test_reset();
        test_minus_saturate();
        test_plus_single();
        test_plus_hold();
        test_boundaries();
        test_both_held();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
